rat_cp_ctrl: RTL

RAT_CP_CTRL -- requirements
Module: rat_cp_ctrl

---
 rtl/rat_cp_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rat_cp_ctrl.sv
// Checkpoint controller for the register alias table: hands out snapshot
// slots one branch lane per cycle, frees the oldest slot on commit, and
// restores a slot (dropping it and everything younger) on misprediction.
module rat_cp_ctrl #(
  parameter int RENAME_WIDTH = 4,
  parameter int CP_SIZE      = 8,
  parameter int CP_IDX_W     = 3,
  localparam int LANE_W      = (RENAME_WIDTH > 1) ? $clog2(RENAME_WIDTH) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rename_valid,
  input  logic [RENAME_WIDTH-1:0] br_mask,
  input  logic                    pause,
  output logic                    rename_ready,
  output logic                    cp_check,
  output logic [CP_IDX_W-1:0]     cp_check_idx,
  output logic [LANE_W-1:0]       cp_check_lane,
  input  logic                    commit_valid,
  input  logic                    recover,
  input  logic [CP_IDX_W-1:0]     recover_idx,
  output logic                    mt_recover,
  output logic [CP_IDX_W-1:0]     mt_recover_idx,
  output logic [CP_IDX_W:0]       cp_count,
  output logic                    checkable
);

  localparam int CNT_W = CP_IDX_W + 1;

  typedef enum logic [1:0] {IDLE, SNAP, RECOVER} state_e;

  state_e                  state_q, state_d;
  logic [CP_IDX_W-1:0]     head_q, head_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [RENAME_WIDTH-1:0] mask_q, mask_d;

  logic [CP_IDX_W-1:0]     tail;
  logic [CP_IDX_W-1:0]     rec_off;
  logic                    rec_hit;
  logic                    commit_ok;
  logic [CNT_W-1:0]        space;
  logic [LANE_W:0]         br_k;
  logic                    snap;

  // Number of branch lanes in a group.
  function automatic logic [LANE_W:0] popcount(input logic [RENAME_WIDTH-1:0] m);
    popcount = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) popcount = popcount + (LANE_W+1)'(m[i]);
  endfunction

  // Index of the lowest set lane (oldest branch in program order).
  function automatic logic [LANE_W-1:0] low_lane(input logic [RENAME_WIDTH-1:0] m);
    low_lane = '0;
    for (int i = RENAME_WIDTH - 1; i >= 0; i--) if (m[i]) low_lane = LANE_W'(i);
  endfunction

  assign tail           = head_q + count_q[CP_IDX_W-1:0];
  assign rec_off        = recover_idx - head_q;
  // A slot is in flight when its distance from head is below the occupancy.
  assign rec_hit        = recover && ({1'b0, rec_off} < count_q);
  assign commit_ok      = commit_valid && (count_q != '0);
  assign space          = CNT_W'(CP_SIZE) - count_q;
  assign br_k           = popcount(br_mask);
  assign cp_check_idx   = tail;
  assign mt_recover_idx = recover_idx;
  assign cp_count       = count_q;
  assign checkable      = (count_q < CNT_W'(CP_SIZE));

  // Next-state, queue pointer and strobe logic; recover outranks snapshots.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_d       = state_q;
    head_d        = head_q;
    count_d       = count_q;
    mask_d        = mask_q;
    rename_ready  = 1'b0;
    cp_check      = 1'b0;
    cp_check_lane = '0;
    mt_recover    = 1'b0;
    snap          = 1'b0;

    if (reset) begin
      state_d = IDLE;
      head_d  = '0;
      count_d = '0;
      mask_d  = '0;
    end else if (rec_hit) begin
      mt_recover = 1'b1;
      // Committing the slot being restored would free it twice.
      if (commit_ok && (recover_idx != head_q)) head_d = head_q + CP_IDX_W'(1);
      count_d = {1'b0, recover_idx - head_d};
      mask_d  = '0;
      state_d = RECOVER;
    end else begin
      case (state_q)
        IDLE: begin
          if (rename_valid && !pause) begin
            if (br_k == '0) begin
              rename_ready = 1'b1;
            end else if (32'(br_k) <= 32'(space)) begin
              // Space for the whole group is reserved up front so SNAP never stalls.
              snap          = 1'b1;
              cp_check_lane = low_lane(br_mask);
              mask_d        = br_mask & (br_mask - RENAME_WIDTH'(1));
              if (br_k == (LANE_W+1)'(1)) rename_ready = 1'b1;
              else                        state_d      = SNAP;
            end
          end
        end
        SNAP: begin
          if (!pause) begin
            snap          = 1'b1;
            cp_check_lane = low_lane(mask_q);
            mask_d        = mask_q & (mask_q - RENAME_WIDTH'(1));
            if (mask_d == '0) begin
              rename_ready = 1'b1;
              state_d      = IDLE;
            end
          end
        end
        RECOVER: state_d = IDLE;
        default: state_d = IDLE;
      endcase

      cp_check = snap;
      if (commit_ok) head_d = head_q + CP_IDX_W'(1);
      count_d = count_q + CNT_W'(snap) - CNT_W'(commit_ok);
    end
  end

  // State registers; reset is folded into the next-state logic above.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    state_q <= state_d;
    head_q  <= head_d;
    count_q <= count_d;
    mask_q  <= mask_d;
  end

endmodule
